// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the 8-lane, 16-bit write-side router.
// Lane a is index 0 and lane h is index 7.
package dmux_pkg;

  localparam int WIDTH = 16;
  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int OCC_W = 4;

  localparam logic [SEL_W-1:0] LANE_A = 3'd0;
  localparam logic [SEL_W-1:0] LANE_B = 3'd1;
  localparam logic [SEL_W-1:0] LANE_C = 3'd2;
  localparam logic [SEL_W-1:0] LANE_D = 3'd3;
  localparam logic [SEL_W-1:0] LANE_E = 3'd4;
  localparam logic [SEL_W-1:0] LANE_F = 3'd5;
  localparam logic [SEL_W-1:0] LANE_G = 3'd6;
  localparam logic [SEL_W-1:0] LANE_H = 3'd7;

  // Count of set bits across the lane valid flags.
  function automatic logic [OCC_W-1:0] popcount_lanes(input logic [LANES-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {{(OCC_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dmux8way16_router_lane_reg.sv
// One-entry holding register for a single output lane.
// A load wins over a drain on the same edge, so the flag stays set.
module lane_reg
  import dmux_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmux8way16_router.sv
// Routes one producer stream into eight one-entry lanes, chosen either by an
// explicit select or by a round-robin pointer that only advances on accepts.
module dmux8way16_router
  import dmux_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   rr_mode,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [SEL_W-1:0]       ptr,
  output logic [OCC_W-1:0]       occupied
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready may depend on the partner's valid/ready in the same cycle
  // (in_ready follows out_ready of the target lane), valid never waits on ready.
  logic [SEL_W-1:0] target;
  logic             accept;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;
  logic [LANES-1:0] next_valid;

  assign target   = rr_mode ? ptr : in_sel;
  assign in_ready = ~out_valid[target] | out_ready[target];
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    load = '0;
    if (accept) load[target] = 1'b1;
  end

  // Mirrors the lane update rule so occupied lands on the same edge as out_valid.
  assign next_valid = load | (out_valid & ~out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      occupied <= '0;
    end else begin
      if (accept && rr_mode) ptr <= ptr + 3'd1;
      occupied <= popcount_lanes(next_valid);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_reg u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .drain     (drain[i]),
      .load_data (in_data),
      .valid     (out_valid[i]),
      .data      (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_dmux8way16_router.sv
// Directed bench for dmux8way16_router: the driver pushes the expected post-accept
// state into exp_q and a monitor pops and compares on every handshake.
module tb_dmux8way16_router;

  localparam int EXP_W = 3 + 16 + 8 + 4 + 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  in_data = '0;
  logic [2:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         rr_mode = 1'b0;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready = '0;
  logic [2:0]   ptr;
  logic [3:0]   occupied;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic fire_s = 1'b0;

  dmux8way16_router dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr),
    .occupied  (occupied)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_word(input int k);
    return out_data[k*16 +: 16];
  endfunction

  // driver: one accepted word, with the state expected right after its edge
  task automatic send(input logic [15:0] d, input logic [2:0] sel, input logic rr,
                      input logic [2:0] lane, input logic [7:0] v,
                      input logic [3:0] occ, input logic [2:0] p);
    in_data  = d;
    in_sel   = sel;
    rr_mode  = rr;
    in_valid = 1'b1;
    exp_q.push_back({lane, d, v, occ, p});
    @(posedge clk); #1;
  endtask

  // monitor: handshake sampled mid-cycle, result compared just after the edge
  always @(negedge clk) fire_s = in_valid & in_ready & ~reset;

  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    #1;
    if (fire_s && !reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: got accept expected none");
      end else begin
        e = exp_q.pop_front();
        check("acc_lane_data", lane_word(int'(e[33:31])), e[30:15]);
        check("acc_out_valid", out_valid, e[14:7]);
        check("acc_occupied", occupied, e[6:3]);
        check("acc_ptr", ptr, e[2:0]);
      end
    end
  end

  logic [15:0] words [8];

  initial begin
    for (int k = 0; k < 8; k++) words[k] = 16'h1234 + 16'(k) * 16'h1111;

    // reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", out_valid, 8'h00);
    check("rst_out_data", out_data, 128'h0);
    check("rst_ptr", ptr, 3'd0);
    check("rst_occupied", occupied, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // single word by select into lane d, then drain it
    send(16'h4567, 3'd3, 1'b0, 3'd3, 8'b0000_1000, 4'd1, 3'd0);
    in_valid = 1'b0;
    out_ready = 8'h08;
    @(posedge clk); #1;
    check("drain_d_valid", out_valid, 8'h00);
    check("drain_d_occ", occupied, 4'd0);
    check("drain_d_data_kept", lane_word(3), 16'h4567);
    out_ready = 8'h00;

    // round-robin fill of all eight lanes
    for (int k = 0; k < 8; k++)
      send(words[k], 3'd0, 1'b1, 3'(k), 8'((16'd1 << (k + 1)) - 16'd1), 4'(k + 1), 3'((k + 1) % 8));
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) check("fill_lane", lane_word(k), words[k]);

    // full and blocked: no accept, pointer does not advance
    in_data = 16'h9999;
    in_valid = 1'b1;
    #1 check("full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check("blocked_ptr", ptr, 3'd0);
    check("blocked_lane_a", lane_word(0), 16'h1234);
    check("blocked_occ", occupied, 4'd8);
    in_valid = 1'b0;

    // drain and accept on lane a at the same edge
    out_ready = 8'h01;
    in_data = 16'hFFFF;
    in_valid = 1'b1;
    #1 check("same_edge_in_ready", in_ready, 1'b1);
    send(16'hFFFF, 3'd0, 1'b1, 3'd0, 8'hFF, 4'd8, 3'd1);
    in_valid = 1'b0;
    out_ready = 8'h00;

    // free lane f, then stall on full lane c and retarget to f
    out_ready = 8'h20;
    @(posedge clk); #1;
    check("drain_f_valid", out_valid, 8'hDF);
    check("drain_f_occ", occupied, 4'd7);
    out_ready = 8'h00;
    rr_mode = 1'b0;
    in_sel = 3'd2;
    in_data = 16'hAAAA;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("stall_c_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("stall_c_data", lane_word(2), 16'h3456);
    send(16'hAAAA, 3'd5, 1'b0, 3'd5, 8'hFF, 4'd8, 3'd1);
    in_valid = 1'b0;

    // multi-lane drain: c..h, then a and b together
    out_ready = 8'hFC;
    @(posedge clk); #1;
    check("drain6_valid", out_valid, 8'h03);
    check("drain6_occ", occupied, 4'd2);
    out_ready = 8'h03;
    @(posedge clk); #1;
    check("drain_ab_valid", out_valid, 8'h00);
    check("drain_ab_occ", occupied, 4'd0);
    check("drain_ab_a_kept", lane_word(0), 16'hFFFF);
    check("drain_ab_b_kept", lane_word(1), 16'h2345);
    check("drain_f_kept", lane_word(5), 16'hAAAA);
    out_ready = 8'h00;

    // five lanes full with ptr=5, then asynchronous reset
    send(16'h0101, 3'd0, 1'b1, 3'd1, 8'b0000_0010, 4'd1, 3'd2);
    send(16'h0202, 3'd0, 1'b1, 3'd2, 8'b0000_0110, 4'd2, 3'd3);
    send(16'h0303, 3'd0, 1'b1, 3'd3, 8'b0000_1110, 4'd3, 3'd4);
    send(16'h0404, 3'd0, 1'b1, 3'd4, 8'b0001_1110, 4'd4, 3'd5);
    send(16'h0707, 3'd7, 1'b0, 3'd7, 8'b1001_1110, 4'd5, 3'd5);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 8'h00);
    check("async_rst_data", out_data, 128'h0);
    check("async_rst_ptr", ptr, 3'd0);
    check("async_rst_occ", occupied, 4'd0);
    in_sel = 3'd0;
    in_data = 16'h5A5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_no_accept", out_valid, 8'h00);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #2;
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
